dpa_scale_xfer: RTL and testbench
=================================

# dpa_scale_xfer

Parametrised photo-transfer engine for the DPA device. It moves one stored photo from image memory into the frame buffer over the single-port memory interface, resampling to the frame-buffer size:

- 2× pixel-replicating upscale for half-size photos.
- 1:1 copy for native-size photos.
- 2×2 rounded-average downscale for double-size photos.

It sits under the top-level DPA controller, which issues one `start` per displayed photo and waits for `done`.

## Interface
- `PIX_W`, default 24: pixel width; multiple of 8, giving PIX_W/8 channels.
- `ADDR_W`, default 20: memory address width.
- `FB_LOG2`, default 8: log2 of frame-buffer side, so the frame buffer is 256×256.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: request a transfer; sampled only in IDLE.
- `abort` in 1: cancel a transfer in progress.
- `src_addr` in ADDR_W: photo base address.
- `src_size` in 2: size code. 01 = half, 10 = native, 11 = double, 00 = invalid.
- `fb_addr` in ADDR_W: frame-buffer base address.
- `im_a` out ADDR_W: memory address.
- `im_wen_n` out 1: write enable, active-low. High means read.
- `im_d` out PIX_W: write data.
- `im_q` in PIX_W: read data, valid the cycle after its address.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: latched when `start` carried an invalid size; cleared by the next `start`.

## Operation
- **Reset values:** `im_a`=0, `im_wen_n`=1, `im_d`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- **States:** IDLE, XFER, DONE.
  - IDLE→XFER on `start` with a valid size.
  - IDLE→DONE on `start` with size 00: sets `err`, makes no memory access.
  - XFER→DONE after the final write.
  - DONE→IDLE unconditionally.
  - `done`=1 only in DONE. `busy`=1 only in XFER.
- **Snapshot:** `src_addr`, `src_size` and `fb_addr` are latched on accepted `start`. Later input changes are ignored. `start` during XFER or DONE is ignored.
- **Phase counter and addressing:**
  - A phase counter steps through each group. Destination coordinates (x, y) advance in raster order, x fastest.
  - Destination address = `fb_addr` + (y<<FB_LOG2) + x.
  - Source address = `src_addr` + (sy<<src_log2) + sx. src_log2 is FB_LOG2-1, FB_LOG2 or FB_LOG2+1 for half, native and double size.
  - Shifts and adds only; no multipliers.
- **Copy (10):** 2 phases per pixel: R(x,y), then W(x,y) with `im_d`=`im_q`.
- **Upscale (01):** 5 phases per source pixel (sx,sy):
  - R, then W(2sx,2sy) with `im_d`=`im_q`.
  - `im_q` is captured into a hold register in that same cycle.
  - Then W(2sx+1,2sy), W(2sx,2sy+1), W(2sx+1,2sy+1) from the hold register.
- **Downscale (11):** 5 phases per destination pixel:
  - Reads at (2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1).
  - The first three returns are accumulated per channel.
  - The fourth `im_q` is added combinationally in the W phase.
  - Each channel result = (a+b+c+d+2)>>2, computed in a 10-bit sum; it cannot overflow.
- **Idle outputs:** outside XFER, `im_wen_n`=1, `im_a`=0, `im_d`=0.
- **Abort:**
  - `abort` in XFER forces `im_wen_n`=1 combinationally in that cycle, and the next state is IDLE.
  - No `done`; `err` is unchanged.
  - `abort` and `start` together in IDLE: abort wins, nothing starts.
- **Reset mid-transfer:** immediate return to IDLE with reset values. No `done`. A partially written frame buffer is acceptable.

## Timing
- **Start:** `start` sampled at edge 0. The first memory access is in cycle 1.
- **Final write and `done`** (final-write cycle; `done` is high the cycle after, `busy` falls with it):
  - Copy: final write in cycle 131072, `done` in cycle 131073.
  - Upscale: 16384×5 = 81920 access cycles, final write in cycle 81920, `done` in 81921.
  - Downscale: 65536×5 = 327680 access cycles, final write in cycle 327680, `done` in 327681.
- **Invalid size:** `done` in cycle 1; `err` high from cycle 1.
- **Back-to-back:** `start` is accepted again in the cycle after DONE, i.e. one idle cycle minimum.

## Structure
- **Package `dpa_pkg`:**
  - Size codes SZ_INV/SZ_HALF/SZ_NAT/SZ_DBL.
  - State encoding IDLE/XFER/DONE.
  - Phases-per-group constants (2, 5, 5).
- **Sub-module `pix_avg4`:** combinational per-channel rounding average of four PIX_W pixels, parametrised by PIX_W.
- **Top level:** holds the FSM, phase and coordinate counters, address generation and the hold/accumulate registers.

## Test plan
- **Copy:** native size, source memory[i]=i. Require `fb_addr`+i = i for all 65536 pixels, `done` in cycle 131073, and strict R/W alternation.
- **Upscale:** half size, pixel (3,5)=0xABCDEF. Require destination (6,10), (7,10), (6,11), (7,11) = 0xABCDEF, and `done` in cycle 81921.
- **Downscale rounding:**
  - Block 0x040404, 0x040404, 0x040404, 0x050505 → 0x040404.
  - Block 0x000000, 0x000001, 0x000001, 0x000001 → 0x000001.
  - All 0xFFFFFF → 0xFFFFFF.
- **Invalid size:** `src_size`=00 → `err`=1 and `done` in cycle 1, zero writes. A following valid `start` clears `err`.
- **Abort:** `abort` at cycle 1000 of a copy → no write in that cycle, IDLE next cycle, no `done`. `start`+`abort` in IDLE → no transfer.
- **Reset and busy-start:** `reset` low mid-downscale → all outputs at reset values immediately. `start` with changed addresses while busy → ignored, original transfer completes unchanged.

Source files
------------

// File: rtl/dpa_pkg.sv
// rtl/dpa_pkg.sv - shared size codes, FSM states and phase counts for the photo-transfer engine
package dpa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_INV  = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_NAT  = 2'b10;
    localparam logic [1:0] SZ_DBL  = 2'b11;

    localparam logic [2:0] PH_NAT  = 3'd2;
    localparam logic [2:0] PH_HALF = 3'd5;
    localparam logic [2:0] PH_DBL  = 3'd5;

    function automatic logic [2:0] last_phase(input logic [1:0] sz);
        if (sz == SZ_NAT) begin
            return PH_NAT - 3'd1;
        end else if (sz == SZ_HALF) begin
            return PH_HALF - 3'd1;
        end
        return PH_DBL - 3'd1;
    endfunction

endpackage

// File: rtl/pix_avg4.sv
// rtl/pix_avg4.sv - per-channel rounded average of four pixels
module pix_avg4 #(
    parameter int PIX_W = 24
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] c_i,
    input  logic [PIX_W-1:0] d_i,
    output logic [PIX_W-1:0] avg_o
);

    for (genvar ch = 0; ch < PIX_W / 8; ch++) begin : g_ch
        // Four 8-bit values plus the rounding constant top out at 1022.
        logic [9:0] sum;
        assign sum = {2'b00, a_i[ch*8+:8]} + {2'b00, b_i[ch*8+:8]}
                   + {2'b00, c_i[ch*8+:8]} + {2'b00, d_i[ch*8+:8]} + 10'd2;
        assign avg_o[ch*8+:8] = 8'(sum >> 2);
    end

endmodule

// File: rtl/dpa_scale_xfer.sv
// rtl/dpa_scale_xfer.sv - photo transfer from image memory to frame buffer with 2x up / 1:1 / 2x2 down resampling
module dpa_scale_xfer
    import dpa_pkg::*;
#(
    parameter int PIX_W   = 24,
    parameter int ADDR_W  = 20,
    parameter int FB_LOG2 = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [1:0]        src_size_i,
    input  logic [ADDR_W-1:0] fb_addr_i,
    output logic [ADDR_W-1:0] im_a_o,
    output logic              im_wen_n_o,
    output logic [PIX_W-1:0]  im_d_o,
    input  logic [PIX_W-1:0]  im_q_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [FB_LOG2-1:0] G_ONE = 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, fb_q;
    logic [1:0]          size_q;
    logic [2:0]          phase_q;
    logic [FB_LOG2-1:0]  gx_q, gy_q;
    logic [PIX_W-1:0]    pa_q, pb_q, pc_q;
    logic                err_q;

    logic                accept, grp_end, xfer_end, is_write, dx, dy;
    logic [FB_LOG2-1:0]  gmax;
    logic [ADDR_W-1:0]   ax, ay, ex, ey, src_off, dst_off;
    logic [PIX_W-1:0]    avg, wr_data;

    assign accept   = (state_q == ST_IDLE) && start_i && !abort_i;
    // Upscale walks source pixels, which span half the frame-buffer side.
    assign gmax     = (size_q == SZ_HALF) ? {1'b0, {(FB_LOG2-1){1'b1}}} : '1;
    assign grp_end  = (phase_q == last_phase(size_q));
    assign xfer_end = grp_end && (gx_q == gmax) && (gy_q == gmax);

    always_comb begin
        dx       = 1'b0;
        dy       = 1'b0;
        is_write = 1'b0;
        case (size_q)
            SZ_HALF: begin
                dx       = (phase_q == 3'd2) || (phase_q == 3'd4);
                dy       = (phase_q >= 3'd3);
                is_write = (phase_q != 3'd0);
            end
            SZ_DBL: begin
                dx       = phase_q[0];
                dy       = phase_q[1];
                is_write = (phase_q == 3'd4);
            end
            default: is_write = (phase_q == 3'd1);
        endcase
    end

    assign ax = ADDR_W'(gx_q);
    assign ay = ADDR_W'(gy_q);
    assign ex = (ax << 1) | ADDR_W'(dx);
    assign ey = (ay << 1) | ADDR_W'(dy);

    always_comb begin
        src_off = (ay << FB_LOG2) + ax;
        dst_off = (ay << FB_LOG2) + ax;
        if (size_q == SZ_HALF) begin
            src_off = (ay << (FB_LOG2 - 1)) + ax;
            dst_off = (ey << FB_LOG2) + ex;
        end else if (size_q == SZ_DBL) begin
            src_off = (ey << (FB_LOG2 + 1)) + ex;
        end
    end

    pix_avg4 #(.PIX_W(PIX_W)) u_avg (
        .a_i  (pa_q),
        .b_i  (pb_q),
        .c_i  (pc_q),
        .d_i  (im_q_i),
        .avg_o(avg)
    );

    always_comb begin
        wr_data = im_q_i;
        if (size_q == SZ_HALF && phase_q != 3'd1) begin
            wr_data = pa_q;
        end else if (size_q == SZ_DBL) begin
            wr_data = avg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (src_size_i == SZ_INV) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (xfer_end) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == ST_XFER);
        done_o     = (state_q == ST_DONE);
        err_o      = err_q;
        im_a_o     = '0;
        im_wen_n_o = 1'b1;
        im_d_o     = '0;
        if (state_q == ST_XFER) begin
            im_a_o     = is_write ? (fb_q + dst_off) : (src_q + src_off);
            im_wen_n_o = !(is_write && !abort_i);
            im_d_o     = is_write ? wr_data : '0;
        end
    end

    // Phase 1 capture doubles as the upscale hold and the first downscale return.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q   <= '0;
            fb_q    <= '0;
            size_q  <= SZ_INV;
            phase_q <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            src_q   <= src_addr_i;
            fb_q    <= fb_addr_i;
            size_q  <= src_size_i;
            phase_q <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            err_q   <= (src_size_i == SZ_INV);
        end else if (state_q == ST_XFER && !abort_i) begin
            case (phase_q)
                3'd1:    pa_q <= im_q_i;
                3'd2:    pb_q <= im_q_i;
                3'd3:    pc_q <= im_q_i;
                default: ;
            endcase
            if (grp_end) begin
                phase_q <= '0;
                if (gx_q == gmax) begin
                    gx_q <= '0;
                    gy_q <= gy_q + G_ONE;
                end else begin
                    gx_q <= gx_q + G_ONE;
                end
            end else begin
                phase_q <= phase_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dpa_scale_xfer.sv
// tb/tb_dpa_scale_xfer.sv - randomized self-checking bench for dpa_scale_xfer on a 16x16 frame buffer
module tb_dpa_scale_xfer;
    import dpa_pkg::*;

    localparam int PW = 24, AW = 12, FL = 4, SIDE = 16, NPIX = 256;
    localparam logic [AW-1:0] SRC = 12'h100, FB = 12'h800;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [AW-1:0] src_addr = '0, fb_addr = '0;
    logic [1:0]    src_size = '0;
    logic [AW-1:0] im_a;
    logic          im_wen_n, busy, done, err;
    logic [PW-1:0] im_d, im_q = '0;
    logic [PW-1:0] mem [0:4095];
    logic [PW-1:0] expv [0:NPIX-1];
    int asserts = 0, fails = 0, wr_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) im_q <= mem[im_a];

    dpa_scale_xfer #(.PIX_W(PW), .ADDR_W(AW), .FB_LOG2(FL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .src_addr_i(src_addr), .src_size_i(src_size), .fb_addr_i(fb_addr),
        .im_a_o(im_a), .im_wen_n_o(im_wen_n), .im_d_o(im_d), .im_q_i(im_q),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    function automatic logic [23:0] avg4(input logic [23:0] a, b, c, d);
        logic [23:0] r;
        int s;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(a[ch*8+:8]) + int'(b[ch*8+:8]) + int'(c[ch*8+:8]) + int'(d[ch*8+:8]);
            r[ch*8+:8] = 8'((s + 2) / 4);
        end
        return r;
    endfunction

    task automatic capture();
        if (im_wen_n === 1'b0) begin
            mem[im_a] = im_d;
            wr_cnt++;
        end
    endtask

    task automatic fill_fb(input logic [AW-1:0] base, input logic [PW-1:0] v);
        for (int i = 0; i < NPIX; i++) mem[base + AW'(i)] = v;
    endtask

    task automatic run_xfer(input logic [1:0] sz, input logic [AW-1:0] sa, input logic [AW-1:0] fa,
                            input int inj_cyc, output int done_cyc, output int nwr,
                            output int alt_bad, output logic err1);
        int w0;
        w0 = wr_cnt; done_cyc = -1; alt_bad = 0; err1 = 1'b0;
        @(negedge clk);
        src_size = sz; src_addr = sa; fb_addr = fa; start = 1'b1;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk);
            start = (n == inj_cyc);
            if (n == inj_cyc) begin
                src_addr = sa + 12'h400; fb_addr = fa + 12'h400; src_size = SZ_DBL;
            end
            #1 capture();
            if (n == 1) err1 = err;
            if ((im_wen_n == 1'b0) != (n % 2 == 0)) alt_bad++;
            if (done === 1'b1) begin
                done_cyc = n;
                break;
            end
        end
        start = 1'b0;
        nwr = wr_cnt - w0;
    endtask

    task automatic check_fb(input string name, input logic [AW-1:0] base);
        int bad, first;
        bad = 0; first = -1;
        for (int i = 0; i < NPIX; i++)
            if (mem[base + AW'(i)] !== expv[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d bad pixels, first idx %0d got %h need %h",
                     name, bad, first, mem[base + AW'(first)], expv[first]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        asserts++; if ({im_a, im_wen_n, im_d, busy, done, err} !== {12'h0, 1'b1, 24'h0, 3'b000}) begin
            fails++; $display("FAIL reset_outputs: got a=%h wen=%b d=%h busy=%b done=%b err=%b",
                              im_a, im_wen_n, im_d, busy, done, err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) #1;
        asserts++; if ({busy, done, im_wen_n} !== 3'b001) begin
            fails++; $display("FAIL reset_idle: busy=%b done=%b wen=%b need 0 0 1", busy, done, im_wen_n);
        end
    endtask

    task automatic test_copy();
        int dc, nw, ab; logic e1;
        for (int i = 0; i < NPIX; i++) begin
            mem[AW'(i)] = PW'(i);
            expv[i] = PW'(i);
        end
        fill_fb(FB, 24'hDEAD00);
        run_xfer(SZ_NAT, 12'h000, FB, 0, dc, nw, ab, e1);
        asserts++; if (dc != 2 * NPIX + 1) begin fails++; $display("FAIL copy_done_cycle: got %0d need %0d", dc, 2 * NPIX + 1); end
        asserts++; if (ab != 0) begin fails++; $display("FAIL copy_rw_alternation: %0d bad cycles need 0", ab); end
        asserts++; if (nw != NPIX) begin fails++; $display("FAIL copy_write_count: got %0d need %0d", nw, NPIX); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL copy_busy_at_done: got %b need 0", busy); end
        check_fb("copy_data", FB);
        @(negedge clk) #1;
        asserts++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL copy_done_pulse: done=%b busy=%b need 0 0", done, busy); end
    endtask

    task automatic test_upscale();
        int dc, nw, ab; logic e1;
        logic [PW-1:0] s [0:63];
        for (int i = 0; i < 64; i++) s[i] = PW'($urandom);
        s[5 * 8 + 3] = 24'hABCDEF;
        for (int i = 0; i < 64; i++) mem[SRC + AW'(i)] = s[i];
        for (int y = 0; y < SIDE; y++)
            for (int x = 0; x < SIDE; x++) expv[y * SIDE + x] = s[(y / 2) * 8 + x / 2];
        fill_fb(FB, 24'h0);
        run_xfer(SZ_HALF, SRC, FB, 0, dc, nw, ab, e1);
        asserts++; if (dc != 64 * 5 + 1) begin fails++; $display("FAIL up_done_cycle: got %0d need %0d", dc, 64 * 5 + 1); end
        asserts++; if (nw != NPIX) begin fails++; $display("FAIL up_write_count: got %0d need %0d", nw, NPIX); end
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] a;
            a = FB + AW'((10 + k / 2) * SIDE + 6 + k % 2);
            asserts++; if (mem[a] !== 24'hABCDEF) begin
                fails++; $display("FAIL up_pixel_3_5_copy%0d: got %h need abcdef", k, mem[a]);
            end
        end
        check_fb("up_data", FB);
    endtask

    task automatic test_downscale();
        int dc, nw, ab; logic e1;
        logic [PW-1:0] s [0:1023];
        logic [PW-1:0] blk [0:2][0:3];
        logic [PW-1:0] need [0:2];
        blk[0] = '{24'h040404, 24'h040404, 24'h040404, 24'h050505}; need[0] = 24'h040404;
        blk[1] = '{24'h000000, 24'h000001, 24'h000001, 24'h000001}; need[1] = 24'h000001;
        blk[2] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}; need[2] = 24'hFFFFFF;
        for (int i = 0; i < 1024; i++) s[i] = PW'($urandom);
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 4; k++) s[(k / 2) * 32 + 2 * b + k % 2] = blk[b][k];
        for (int i = 0; i < 1024; i++) mem[SRC + AW'(i)] = s[i];
        for (int y = 0; y < SIDE; y++)
            for (int x = 0; x < SIDE; x++)
                expv[y * SIDE + x] = avg4(s[2 * y * 32 + 2 * x], s[2 * y * 32 + 2 * x + 1],
                                          s[(2 * y + 1) * 32 + 2 * x], s[(2 * y + 1) * 32 + 2 * x + 1]);
        fill_fb(FB, 24'h0);
        run_xfer(SZ_DBL, SRC, FB, 0, dc, nw, ab, e1);
        asserts++; if (dc != NPIX * 5 + 1) begin fails++; $display("FAIL down_done_cycle: got %0d need %0d", dc, NPIX * 5 + 1); end
        for (int b = 0; b < 3; b++) begin
            asserts++; if (mem[FB + AW'(b)] !== need[b]) begin
                fails++; $display("FAIL down_round_block%0d: got %h need %h", b, mem[FB + AW'(b)], need[b]);
            end
        end
        check_fb("down_data", FB);
    endtask

    task automatic test_invalid_back_to_back();
        int dc, nw, ab; logic e1;
        run_xfer(SZ_INV, SRC, FB, 0, dc, nw, ab, e1);
        asserts++; if (dc != 1) begin fails++; $display("FAIL inv_done_cycle: got %0d need 1", dc); end
        asserts++; if (nw != 0) begin fails++; $display("FAIL inv_writes: got %0d need 0", nw); end
        asserts++; if (e1 !== 1'b1) begin fails++; $display("FAIL inv_err_set: got %b need 1", e1); end
        for (int i = 0; i < NPIX; i++) begin
            mem[AW'(i)] = PW'(i) ^ 24'h5A5A00;
            expv[i] = PW'(i) ^ 24'h5A5A00;
        end
        run_xfer(SZ_NAT, 12'h000, FB, 0, dc, nw, ab, e1);
        asserts++; if (e1 !== 1'b0) begin fails++; $display("FAIL b2b_err_cleared: got %b need 0", e1); end
        asserts++; if (dc != 2 * NPIX + 1) begin fails++; $display("FAIL b2b_done_cycle: got %0d need %0d", dc, 2 * NPIX + 1); end
        check_fb("b2b_data", FB);
    endtask

    task automatic test_abort();
        int w0, ndone;
        fill_fb(FB, 24'hDEAD00);
        for (int i = 0; i < NPIX; i++) mem[AW'(i)] = PW'(i);
        w0 = wr_cnt; ndone = 0;
        @(negedge clk);
        src_size = SZ_NAT; src_addr = 12'h000; fb_addr = FB; start = 1'b1;
        for (int n = 1; n <= 106; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 100) begin
                #1;
                asserts++; if (im_wen_n !== 1'b0) begin fails++; $display("FAIL abort_pre_write: wen=%b need 0", im_wen_n); end
                abort = 1'b1;
                #1;
                asserts++; if (im_wen_n !== 1'b1) begin fails++; $display("FAIL abort_blocks_write: wen=%b need 1", im_wen_n); end
                capture();
            end else begin
                abort = 1'b0;
                #1 capture();
                if (n == 101) begin
                    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_to_idle: busy=%b need 0", busy); end
                end
            end
            if (n >= 100 && done === 1'b1) ndone++;
        end
        asserts++; if (ndone != 0) begin fails++; $display("FAIL abort_no_done: %0d done cycles need 0", ndone); end
        asserts++; if (wr_cnt - w0 != 49) begin fails++; $display("FAIL abort_write_count: got %0d need 49", wr_cnt - w0); end
        asserts++; if (mem[FB + 12'd49] !== 24'hDEAD00) begin fails++; $display("FAIL abort_pixel49: got %h need dead00", mem[FB + 12'd49]); end
        asserts++; if (err !== 1'b0) begin fails++; $display("FAIL abort_err_kept: got %b need 0", err); end
        w0 = wr_cnt; ndone = 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            #1 capture();
            if (busy !== 1'b0 || done !== 1'b0) ndone++;
        end
        asserts++; if (ndone != 0 || wr_cnt != w0) begin
            fails++; $display("FAIL start_abort_idle: active cycles %0d writes %0d need 0 0", ndone, wr_cnt - w0);
        end
    endtask

    task automatic test_busy_start();
        int dc, nw, ab, changed; logic e1;
        for (int i = 0; i < NPIX; i++) begin
            mem[AW'(i)] = PW'($urandom);
            expv[i] = mem[AW'(i)];
        end
        fill_fb(FB, 24'h0);
        fill_fb(FB + 12'h400, 24'h777777);
        run_xfer(SZ_NAT, 12'h000, FB, 50, dc, nw, ab, e1);
        asserts++; if (dc != 2 * NPIX + 1) begin fails++; $display("FAIL busy_start_done_cycle: got %0d need %0d", dc, 2 * NPIX + 1); end
        check_fb("busy_start_data", FB);
        changed = 0;
        for (int i = 0; i < NPIX; i++) if (mem[FB + 12'h400 + AW'(i)] !== 24'h777777) changed++;
        asserts++; if (changed != 0) begin fails++; $display("FAIL busy_start_other_fb: %0d pixels touched need 0", changed); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        for (int i = 0; i < 1024; i++) mem[SRC + AW'(i)] = PW'($urandom);
        @(negedge clk);
        src_size = SZ_DBL; src_addr = SRC; fb_addr = FB; start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            #1 capture();
        end
        #1 rst_n = 1'b0;
        #1;
        asserts++; if ({im_a, im_wen_n, im_d, busy, done, err} !== {12'h0, 1'b1, 24'h0, 3'b000}) begin
            fails++; $display("FAIL reset_mid_outputs: got a=%h wen=%b d=%h busy=%b done=%b err=%b",
                              im_a, im_wen_n, im_d, busy, done, err);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk) #1;
            if (busy !== 1'b0 || done !== 1'b0 || im_wen_n !== 1'b1) ndone++;
        end
        asserts++; if (ndone != 0) begin fails++; $display("FAIL reset_mid_idle: %0d active cycles need 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_upscale();
        test_downscale();
        test_invalid_back_to_back();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
